// File: rtl/mem_arbiter_pkg.sv
// Shared arbiter definitions: FSM encodings, access size codes and pipeline stall patterns.
package mem_arbiter_pkg;

    localparam logic STOP    = 1'b1;
    localparam logic NO_STOP = 1'b0;

    localparam int STALL_PC     = 0;
    localparam int STALL_IF_ID  = 1;
    localparam int STALL_ID_EX  = 2;
    localparam int STALL_EX_MEM = 3;
    localparam int STALL_MEM_WB = 4;
    localparam int STALL_WB     = 5;

    typedef enum logic [1:0] {
        ARB_IDLE   = 2'd0,
        ARB_IF_RD  = 2'd1,
        ARB_MEM_RD = 2'd2,
        ARB_MEM_WR = 2'd3
    } arb_state_e;

    localparam logic [1:0] SIZE_B = 2'b00;
    localparam logic [1:0] SIZE_H = 2'b01;
    localparam logic [1:0] SIZE_W = 2'b10;

    localparam logic [5:0] STALL_MEM  = 6'b011111;
    localparam logic [5:0] STALL_ID   = 6'b000111;
    localparam logic [5:0] STALL_IF   = 6'b000011;
    localparam logic [5:0] STALL_NONE = 6'b000000;

    // Size code 2'b11 is treated as a full word.
    function automatic logic [2:0] size_bytes(input logic [1:0] size);
        case (size)
            SIZE_B:  size_bytes = 3'd1;
            SIZE_H:  size_bytes = 3'd2;
            default: size_bytes = 3'd4;
        endcase
    endfunction

endpackage

// File: rtl/mem_arbiter.sv
// Shares one byte-wide synchronous RAM port between IF fetches and MEM accesses; word fetch done 6 cycles after request.
// Requesters are held by the combinational stall vector until their done pulse is consumed.
module mem_arbiter
    import mem_arbiter_pkg::*;
#(
    parameter int ADDR_W = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              if_req,
    input  logic [ADDR_W-1:0] if_addr,
    output logic              if_done,
    output logic [31:0]       if_data,
    input  logic              mem_req,
    input  logic              mem_we,
    input  logic [1:0]        mem_size,
    input  logic [ADDR_W-1:0] mem_addr,
    input  logic [31:0]       mem_wdata,
    output logic              mem_done,
    output logic [31:0]       mem_rdata,
    input  logic              id_stallreq,
    output logic [5:0]        stall,
    output logic [ADDR_W-1:0] ram_a,
    output logic [7:0]        ram_dout,
    output logic              ram_wr,
    input  logic [7:0]        ram_din
);

    arb_state_e        state_q, state_d;
    logic [2:0]        k_q, k_d;
    logic [2:0]        n_q, n_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [31:0]       wdata_q, wdata_d;
    logic [ADDR_W-1:0] ram_a_q, ram_a_d;
    logic [7:0]        ram_dout_q, ram_dout_d;
    logic              ram_wr_q, ram_wr_d;
    logic              if_done_q, if_done_d;
    logic [31:0]       if_data_q, if_data_d;
    logic              mem_done_q, mem_done_d;
    logic [31:0]       mem_rdata_q, mem_rdata_d;

    logic [2:0]        k_inc;
    logic [1:0]        byte_idx;

    assign k_inc    = k_q + 3'd1;
    assign byte_idx = k_q[1:0] - 2'd1;

    // A done requester still shows req high; it must not re-trigger a transfer.
    always_comb begin
        if (mem_req && !mem_done_q) begin
            stall = STALL_MEM;
        end else if (id_stallreq) begin
            stall = STALL_ID;
        end else if (if_req && !if_done_q) begin
            stall = STALL_IF;
        end else begin
            stall = STALL_NONE;
        end
    end

    always_comb begin
        state_d     = state_q;
        k_d         = k_q;
        n_d         = n_q;
        addr_d      = addr_q;
        wdata_d     = wdata_q;
        ram_a_d     = ram_a_q;
        ram_dout_d  = ram_dout_q;
        ram_wr_d    = ram_wr_q;
        if_done_d   = if_done_q;
        if_data_d   = if_data_q;
        mem_done_d  = mem_done_q;
        mem_rdata_d = mem_rdata_q;

        if (if_done_q && stall[STALL_IF_ID] == NO_STOP) begin
            if_done_d = 1'b0;
        end
        if (mem_done_q && stall[STALL_MEM_WB] == NO_STOP) begin
            mem_done_d = 1'b0;
        end

        case (state_q)
            ARB_IDLE: begin
                ram_wr_d = 1'b0;
                if (mem_req && !mem_done_q) begin
                    state_d    = mem_we ? ARB_MEM_WR : ARB_MEM_RD;
                    k_d        = 3'd0;
                    n_d        = size_bytes(mem_size);
                    addr_d     = mem_addr;
                    wdata_d    = mem_wdata;
                    ram_a_d    = mem_addr;
                    ram_dout_d = mem_wdata[7:0];
                    ram_wr_d   = mem_we;
                    if (!mem_we) begin
                        mem_rdata_d = '0;
                    end
                end else if (if_req && !if_done_q) begin
                    state_d = ARB_IF_RD;
                    k_d     = 3'd0;
                    n_d     = 3'd4;
                    addr_d  = if_addr;
                    ram_a_d = if_addr;
                end
            end

            // ram_a runs one cycle ahead of the byte landing on ram_din.
            ARB_IF_RD, ARB_MEM_RD: begin
                k_d = k_inc;
                if (k_q != 3'd0) begin
                    if (state_q == ARB_IF_RD) begin
                        if_data_d[{byte_idx, 3'b000} +: 8] = ram_din;
                    end else begin
                        mem_rdata_d[{byte_idx, 3'b000} +: 8] = ram_din;
                    end
                end
                if (k_q < n_q - 3'd1) begin
                    ram_a_d = addr_q + ADDR_W'(k_inc);
                end
                if (k_q == n_q) begin
                    state_d = ARB_IDLE;
                    k_d     = 3'd0;
                    if (state_q == ARB_IF_RD) begin
                        if_done_d = 1'b1;
                    end else begin
                        mem_done_d = 1'b1;
                    end
                end
            end

            ARB_MEM_WR: begin
                k_d = k_inc;
                if (k_q == n_q - 3'd1) begin
                    state_d    = ARB_IDLE;
                    k_d        = 3'd0;
                    ram_wr_d   = 1'b0;
                    mem_done_d = 1'b1;
                end else begin
                    ram_a_d    = addr_q + ADDR_W'(k_inc);
                    ram_dout_d = wdata_q[{k_inc[1:0], 3'b000} +: 8];
                    ram_wr_d   = 1'b1;
                end
            end

            default: state_d = ARB_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= ARB_IDLE;
            k_q         <= '0;
            n_q         <= '0;
            addr_q      <= '0;
            wdata_q     <= '0;
            ram_a_q     <= '0;
            ram_dout_q  <= '0;
            ram_wr_q    <= 1'b0;
            if_done_q   <= 1'b0;
            if_data_q   <= '0;
            mem_done_q  <= 1'b0;
            mem_rdata_q <= '0;
        end else begin
            state_q     <= state_d;
            k_q         <= k_d;
            n_q         <= n_d;
            addr_q      <= addr_d;
            wdata_q     <= wdata_d;
            ram_a_q     <= ram_a_d;
            ram_dout_q  <= ram_dout_d;
            ram_wr_q    <= ram_wr_d;
            if_done_q   <= if_done_d;
            if_data_q   <= if_data_d;
            mem_done_q  <= mem_done_d;
            mem_rdata_q <= mem_rdata_d;
        end
    end

    assign if_done   = if_done_q;
    assign if_data   = if_data_q;
    assign mem_done  = mem_done_q;
    assign mem_rdata = mem_rdata_q;
    assign ram_a     = ram_a_q;
    assign ram_dout  = ram_dout_q;
    assign ram_wr    = ram_wr_q;

endmodule
